// File: rtl/spi_sram_responder_pkg.sv
// Shared definitions for the SPI serial-SRAM responder.
//   - Command opcodes understood by the responder.
//   - FSM state encoding.
package spi_sram_responder_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDMR  = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_H,
    ADDR_L,
    WRITE,
    READ,
    RDMR,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_sram_responder_if.sv
// Bus bundle for the SPI serial-SRAM responder.
//   SPI side : spi_sck, spi_mosi, spi_cs (active low) in; spi_miso out.
//   Memory   : mem_addr, mem_we, mem_wdata, mem_re out; mem_rdata in
//              (registered read, data valid the clk after mem_re).
//   Status   : active (frame selected), byte_done (1-clk pulse per data byte).
// The responder uses the slave modport; the SPI master / memory side uses master.
interface spi_sram_responder_if #(
  parameter int ADDR_W = 16
);
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_cs;
  logic              spi_miso;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              active;
  logic              byte_done;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs, mem_rdata,
    output spi_miso, mem_addr, mem_we, mem_wdata, mem_re, active, byte_done
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs, mem_rdata,
    input  spi_miso, mem_addr, mem_we, mem_wdata, mem_re, active, byte_done
  );
endinterface

// File: rtl/spi_sram_responder_sync.sv
// spi_in_sync: oversampling front end for the SPI inputs.
//   clk, rst        : system clock, synchronous active-high reset
//   sck, mosi, cs   : raw asynchronous SPI inputs
//   mosi_s, cs_s    : synchronised mosi / chip select
//   sck_rise        : 1-clk flag, synchronised sck went 0 -> 1
//   sck_fall        : 1-clk flag, synchronised sck went 1 -> 0
// Each input passes through a SYNC_STAGES-deep flop chain. Chains reset to
// the idle bus levels (sck low, cs high) so no edge or select is seen on
// reset release.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  input  logic cs,
  output logic mosi_s,
  output logic cs_s,
  output logic sck_rise,
  output logic sck_fall
);

  localparam logic [2:0] IDLE_LEVEL = 3'b100;  // {cs, mosi, sck}

  logic [2:0] raw;
  logic [2:0] synced;
  logic       sck_prev_reg;

  assign raw = {cs, mosi, sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk) begin
        if (rst) chain_reg <= {SYNC_STAGES{IDLE_LEVEL[gi]}};
        else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
      end
      assign synced[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) sck_prev_reg <= 1'b0;
    else     sck_prev_reg <= synced[0];
  end

  assign mosi_s   = synced[1];
  assign cs_s     = synced[2];
  assign sck_rise = synced[0] & ~sck_prev_reg;
  assign sck_fall = ~synced[0] & sck_prev_reg;

endmodule

// File: rtl/spi_sram_responder.sv
// spi_sram_responder: SPI mode-0 target emulating a 23LC1024-style serial
// SRAM (READ 0x03, WRITE 0x02, RDMR 0x05) on a byte-wide memory port.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_sram_responder_if.slave (SPI pins, memory port, status)
// All outputs are registered; SPI inputs are oversampled through spi_in_sync.
module spi_sram_responder
  import spi_sram_responder_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MODE_BYTE   = 8'h40
) (
  input logic clk,
  input logic rst,
  spi_sram_responder_if.slave bus
);

  logic mosi_s, cs_s, sck_rise, sck_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (bus.spi_sck),
    .mosi     (bus.spi_mosi),
    .cs       (bus.spi_cs),
    .mosi_s   (mosi_s),
    .cs_s     (cs_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  state_t            state_reg, state_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        rx_reg, rx_next;
  logic [7:0]        tx_reg, tx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              is_write_reg, is_write_next;
  logic              load_reg, load_next;
  logic              miso_reg, miso_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              mem_we_reg, mem_we_next;
  logic              mem_re_reg, mem_re_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic              active_reg, active_next;
  logic              byte_done_reg, byte_done_next;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_shift;
  logic              byte_end;

  assign rx_byte    = {rx_reg[6:0], mosi_s};
  assign addr_shift = {addr_reg[ADDR_W-2:0], mosi_s};
  assign byte_end   = sck_rise && (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      addr_reg      <= '0;
      is_write_reg  <= 1'b0;
      load_reg      <= 1'b0;
      miso_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      active_reg    <= 1'b0;
      byte_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_reg        <= rx_next;
      tx_reg        <= tx_next;
      addr_reg      <= addr_next;
      is_write_reg  <= is_write_next;
      load_reg      <= load_next;
      miso_reg      <= miso_next;
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_re_reg    <= mem_re_next;
      mem_wdata_reg <= mem_wdata_next;
      active_reg    <= active_next;
      byte_done_reg <= byte_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_next        = rx_reg;
    tx_next        = tx_reg;
    addr_next      = addr_reg;
    is_write_next  = is_write_reg;
    load_next      = mem_re_reg;  // registered memory: data valid one clk after mem_re
    miso_next      = miso_reg;
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
    mem_wdata_next = mem_wdata_reg;
    active_next    = ~cs_s;
    byte_done_next = 1'b0;

    if (cs_s) begin
      // Deselect wins over any SCK edge seen in the same clk; a partial byte is dropped.
      state_next   = IDLE;
      bit_cnt_next = '0;
      rx_next      = '0;
      miso_next    = 1'b0;
      load_next    = 1'b0;
    end else begin
      if (load_reg) tx_next = bus.mem_rdata;
      if (sck_rise) begin
        bit_cnt_next = bit_cnt_reg + 3'd1;
        rx_next      = rx_byte;
      end
      // Mode 0: the target changes MISO on the falling edge so it is stable at the next rise.
      if (sck_fall && (state_reg == READ || state_reg == RDMR)) begin
        miso_next = tx_reg[7];
        tx_next   = {tx_reg[6:0], 1'b0};
      end

      case (state_reg)
        IDLE: begin
          state_next   = CMD;
          bit_cnt_next = '0;
        end
        CMD: begin
          if (byte_end) begin
            case (rx_byte)
              CMD_WRITE: begin
                state_next    = ADDR_H;
                is_write_next = 1'b1;
              end
              CMD_READ: begin
                state_next    = ADDR_H;
                is_write_next = 1'b0;
              end
              CMD_RDMR: begin
                state_next = RDMR;
                tx_next    = MODE_BYTE;
              end
              default: state_next = IGNORE;
            endcase
          end
        end
        ADDR_H: begin
          if (sck_rise) addr_next = addr_shift;
          if (byte_end) state_next = ADDR_L;
        end
        ADDR_L: begin
          if (sck_rise) addr_next = addr_shift;
          if (byte_end) begin
            if (is_write_reg) begin
              state_next = WRITE;
            end else begin
              state_next    = READ;
              mem_re_next   = 1'b1;
              mem_addr_next = addr_shift;
            end
          end
        end
        WRITE: begin
          if (byte_end) begin
            mem_we_next    = 1'b1;
            mem_wdata_next = rx_byte;
            mem_addr_next  = addr_reg;
            byte_done_next = 1'b1;
            addr_next      = addr_reg + 1'b1;
          end
        end
        READ: begin
          // Prefetch the next byte as soon as the current one is fully clocked.
          if (byte_end) begin
            byte_done_next = 1'b1;
            addr_next      = addr_reg + 1'b1;
            mem_re_next    = 1'b1;
            mem_addr_next  = addr_reg + 1'b1;
          end
        end
        RDMR: begin
          if (byte_end) tx_next = MODE_BYTE;
        end
        IGNORE: miso_next = 1'b0;
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.spi_miso  = miso_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.active    = active_reg;
  assign bus.byte_done = byte_done_reg;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: bit-banged SPI master,
// registered-read memory model, scoreboard queues for strobes and MISO bytes.
module tb_spi_sram_responder;

  localparam int HALF = 6;  // SCK half-period in clk cycles

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_sram_responder_if #(.ADDR_W(16)) bus ();

  spi_sram_responder #(
    .ADDR_W      (16),
    .SYNC_STAGES (2),
    .MODE_BYTE   (8'h40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int bd_cnt  = 0;

  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_miso[$];

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] tx_buf  [0:15];
  logic [7:0] rx_buf  [0:15];
  logic [7:0] dat_buf [0:15];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: registered read, data valid the clk after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Strobe monitor / scoreboard pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we || bus.mem_re)
        check_eq("strobe_excl", 32'(bus.mem_we & bus.mem_re), 32'd0);
      if (bus.mem_we) begin
        if (exp_wr.size() != 0) check_eq("mem_we", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_wr.pop_front()));
        else                    check_eq("unexpected_we", 32'({bus.mem_addr, bus.mem_wdata}), 32'hFFFF_FFFF);
      end
      if (bus.mem_re) begin
        if (exp_rd.size() != 0) check_eq("mem_re", 32'(bus.mem_addr), 32'(exp_rd.pop_front()));
        else                    check_eq("unexpected_re", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end
      if (bus.byte_done) bd_cnt++;
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    @(negedge clk) bus.spi_mosi = b;
    repeat (HALF) @(negedge clk);
    r = bus.spi_miso;
    bus.spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], rb);
      r[i] = rb;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk) bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    check_eq("active", 32'(bus.active), 32'd1);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("active_idle", 32'(bus.active), 32'd0);
  endtask

  task automatic run_frame(input int n, input int bd_exp);
    int bd0;
    bd0 = bd_cnt;
    spi_begin();
    for (int i = 0; i < n; i++) spi_byte(tx_buf[i], rx_buf[i]);
    spi_end();
    for (int i = 0; i < n; i++) check_eq("miso_byte", 32'(rx_buf[i]), 32'(exp_miso.pop_front()));
    check_eq("byte_done_cnt", 32'(bd_cnt - bd0), 32'(bd_exp));
    check_eq("wr_left", 32'(exp_wr.size()), 32'd0);
    check_eq("rd_left", 32'(exp_rd.size()), 32'd0);
    $display("frame cmd=%02h len=%0d byte_done=%0d", tx_buf[0], n, bd_cnt - bd0);
  endtask

  task automatic wr_frame(input logic [15:0] a, input int n);
    logic [15:0] ad;
    tx_buf[0] = 8'h02; tx_buf[1] = a[15:8]; tx_buf[2] = a[7:0];
    for (int i = 0; i < n; i++) begin
      ad = a + 16'(i);
      tx_buf[3+i] = dat_buf[i];
      exp_wr.push_back({ad, dat_buf[i]});
      ref_mem[ad] = dat_buf[i];
    end
    for (int i = 0; i < n + 3; i++) exp_miso.push_back(8'h00);
    run_frame(n + 3, n);
  endtask

  task automatic rd_frame(input logic [15:0] a, input int n);
    tx_buf[0] = 8'h03; tx_buf[1] = a[15:8]; tx_buf[2] = a[7:0];
    for (int i = 0; i < 3; i++) exp_miso.push_back(8'h00);
    for (int i = 0; i < n; i++) begin
      tx_buf[3+i] = 8'h00;
      exp_miso.push_back(ref_mem[a + 16'(i)]);
    end
    for (int i = 0; i <= n; i++) exp_rd.push_back(a + 16'(i));
    run_frame(n + 3, n);
  endtask

  task automatic other_frame(input logic [7:0] cmd, input logic [7:0] reply);
    tx_buf[0] = cmd; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    exp_miso.push_back(8'h00);
    exp_miso.push_back(reply);
    exp_miso.push_back(reply);
    run_frame(3, 0);
  endtask

  task automatic check_reset_outputs(input string ph);
    check_eq({ph, "_miso"},  32'(bus.spi_miso),  32'd0);
    check_eq({ph, "_we"},    32'(bus.mem_we),    32'd0);
    check_eq({ph, "_re"},    32'(bus.mem_re),    32'd0);
    check_eq({ph, "_addr"},  32'(bus.mem_addr),  32'd0);
    check_eq({ph, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check_eq({ph, "_active"},32'(bus.active),    32'd0);
    check_eq({ph, "_bdone"}, 32'(bus.byte_done), 32'd0);
  endtask

  initial begin
    logic [7:0] junk;
    logic       jb;
    logic [7:0] abort_bytes [0:2];
    rst = 1'b1;
    bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0; bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    dat_buf[0] = 8'hA5; dat_buf[1] = 8'h5A;
    wr_frame(16'h1234, 2);
    dat_buf[0] = 8'h11; dat_buf[1] = 8'h22; dat_buf[2] = 8'h33;
    wr_frame(16'h1234, 3);
    rd_frame(16'h1234, 3);
    dat_buf[0] = 8'h01; dat_buf[1] = 8'h02;
    wr_frame(16'hFFFF, 2);
    other_frame(8'h05, 8'h40);
    other_frame(8'h9F, 8'h00);

    // Abort inside a write data byte: nothing may be written.
    abort_bytes[0] = 8'h02; abort_bytes[1] = 8'h12; abort_bytes[2] = 8'h34;
    spi_begin();
    for (int i = 0; i < 3; i++) spi_byte(abort_bytes[i], junk);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, jb);
    spi_end();
    check_eq("abort_wr_left", 32'(exp_wr.size()), 32'd0);
    $display("frame cmd=02 aborted after 5 data bits");
    rd_frame(16'hFFFF, 2);
    rd_frame(16'h1234, 1);

    // Reset in the middle of a read data byte.
    exp_rd.push_back(16'h1234);
    spi_begin();
    for (int i = 0; i < 3; i++) spi_byte(abort_bytes[i] | ((i == 0) ? 8'h01 : 8'h00), junk);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, jb);
    check_eq("pre_rst_active", 32'(bus.active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    bus.spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("midrst_rd_left", 32'(exp_rd.size()), 32'd0);
    $display("frame cmd=03 interrupted by reset");

    // Loopback: five random bytes written then read back.
    for (int i = 0; i < 5; i++) dat_buf[i] = 8'($urandom_range(0, 255));
    wr_frame(16'h4000, 5);
    rd_frame(16'h4000, 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
